// File: rtl/seq_store_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_store_if : loader, read and status bundle for seq_store_nch. Rev 1.0
// ---------------------------------------------------------------------------
interface seq_store_if #(
  parameter int N_CH  = 2,
  parameter int DEPTH = 128,
  parameter int SYM_W = 3,
  parameter int AW    = $clog2(DEPTH + 1),
  parameter int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                 wr_start;
  logic [CW-1:0]        wr_ch;
  logic                 wr_valid;
  logic [SYM_W-1:0]     wr_data;
  logic                 wr_last;
  logic                 wr_ready;
  logic                 rd_en;
  logic [CW-1:0]        rd_ch;
  logic [AW-1:0]        rd_addr;
  logic [SYM_W-1:0]     rd_data;
  logic                 rd_valid;
  logic                 rd_oob;
  logic [N_CH*AW-1:0]   len_flat;
  logic [N_CH-1:0]      loaded;
  logic [N_CH-1:0]      ovf;

  modport master (
    output wr_start, wr_ch, wr_valid, wr_data, wr_last, rd_en, rd_ch, rd_addr,
    input  wr_ready, rd_data, rd_valid, rd_oob, len_flat, loaded, ovf
  );

  modport slave (
    input  wr_start, wr_ch, wr_valid, wr_data, wr_last, rd_en, rd_ch, rd_addr,
    output wr_ready, rd_data, rd_valid, rd_oob, len_flat, loaded, ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_store_nch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_store_nch : multi-channel nucleotide sequence store, stream loader and
// 1-cycle bounds-checked read port. Rev 1.0
// ---------------------------------------------------------------------------
module seq_store_nch #(
  parameter int N_CH  = 2,
  parameter int DEPTH = 128,
  parameter int SYM_W = 3,
  parameter int AW    = $clog2(DEPTH + 1),
  parameter int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic       clk,
  input  logic       rst,
  seq_store_if.slave bus
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [CW-1:0]              ch_q, ch_d;
  logic [AW-1:0]              ptr_q, ptr_d;
  logic [N_CH-1:0][AW-1:0]    len_q, len_d;
  logic [N_CH-1:0]            loaded_q, loaded_d;
  logic [N_CH-1:0]            ovf_q, ovf_d;
  logic [SYM_W-1:0]           rd_data_q, rd_data_d;
  logic                       rd_valid_q, rd_valid_d;
  logic                       rd_oob_q, rd_oob_d;
  logic                       wr_en;
  logic                       rd_hit;
  logic [SYM_W-1:0]           rd_sym;

  // Storage is intentionally unreset; len and flags alone define validity.
  logic [SYM_W-1:0] mem_q [N_CH][DEPTH];

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    loaded_d = loaded_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wr_start && (int'(bus.wr_ch) < N_CH)) begin
          ch_d                = bus.wr_ch;
          len_d[bus.wr_ch]    = '0;
          loaded_d[bus.wr_ch] = 1'b0;
          ovf_d[bus.wr_ch]    = 1'b0;
          ptr_d               = '0;
          state_d             = LOAD;
        end
      end
      LOAD: begin
        if (bus.wr_valid) begin
          if (ptr_q < DEPTH_A) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + AW'(1);
          end else begin
            ovf_d[ch_q] = 1'b1;
          end
          if (bus.wr_last) begin
            // min(ptr+1, DEPTH): a full channel keeps length DEPTH.
            len_d[ch_q]    = (ptr_q < DEPTH_A) ? ptr_q + AW'(1) : DEPTH_A;
            loaded_d[ch_q] = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory is read combinationally before the edge, so a same-cycle write
  // to the same cell returns the old contents.
  always_comb begin
    rd_hit     = 1'b0;
    rd_sym     = '0;
    if (int'(bus.rd_ch) < N_CH) begin
      rd_hit = bus.rd_addr < len_q[bus.rd_ch];
      if (rd_hit) begin
        rd_sym = mem_q[bus.rd_ch][bus.rd_addr[IW-1:0]];
      end
    end
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    rd_oob_d   = rd_oob_q;
    if (bus.rd_en) begin
      rd_data_d = rd_sym;
      rd_oob_d  = !rd_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      loaded_q   <= '0;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      loaded_q   <= loaded_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_oob_q   <= rd_oob_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[ch_q][ptr_q[IW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.wr_ready = (state_q == LOAD);
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_oob   = rd_oob_q;
  assign bus.len_flat = len_q;
  assign bus.loaded   = loaded_q;
  assign bus.ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_store_nch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_store_nch : directed bench for seq_store_nch (DEPTH 128 and 4). Rev 1.0
// ---------------------------------------------------------------------------
module tb_seq_store_nch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_store_if #(.N_CH(2), .DEPTH(128), .SYM_W(3)) bus  ();
  seq_store_if #(.N_CH(2), .DEPTH(4),   .SYM_W(3)) bus4 ();

  seq_store_nch #(.N_CH(2), .DEPTH(128), .SYM_W(3)) dut  (.clk(clk), .rst(rst), .bus(bus));
  seq_store_nch #(.N_CH(2), .DEPTH(4),   .SYM_W(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // Shared stimulus; sel4 steers the strobes to the DEPTH=4 instance.
  logic       sel4, wr_start, wr_ch, wr_valid, wr_last, rd_en, rd_ch;
  logic [2:0] wr_data;
  logic [7:0] rd_addr;

  assign bus.wr_start  = wr_start & ~sel4;
  assign bus.wr_valid  = wr_valid & ~sel4;
  assign bus.rd_en     = rd_en    & ~sel4;
  assign bus.wr_ch     = wr_ch;
  assign bus.wr_data   = wr_data;
  assign bus.wr_last   = wr_last;
  assign bus.rd_ch     = rd_ch;
  assign bus.rd_addr   = rd_addr;
  assign bus4.wr_start = wr_start & sel4;
  assign bus4.wr_valid = wr_valid & sel4;
  assign bus4.rd_en    = rd_en    & sel4;
  assign bus4.wr_ch    = wr_ch;
  assign bus4.wr_data  = wr_data;
  assign bus4.wr_last  = wr_last;
  assign bus4.rd_ch    = rd_ch;
  assign bus4.rd_addr  = rd_addr[2:0];

  logic       o_ready, o_valid, o_oob;
  logic [2:0] o_data;
  logic [7:0] o_len0, o_len1;
  logic [1:0] o_loaded, o_ovf;

  always_comb begin
    if (sel4) begin
      o_ready  = bus4.wr_ready;
      o_valid  = bus4.rd_valid;
      o_oob    = bus4.rd_oob;
      o_data   = bus4.rd_data;
      o_len0   = {5'b0, bus4.len_flat[2:0]};
      o_len1   = {5'b0, bus4.len_flat[5:3]};
      o_loaded = bus4.loaded;
      o_ovf    = bus4.ovf;
    end else begin
      o_ready  = bus.wr_ready;
      o_valid  = bus.rd_valid;
      o_oob    = bus.rd_oob;
      o_data   = bus.rd_data;
      o_len0   = bus.len_flat[7:0];
      o_len1   = bus.len_flat[15:8];
      o_loaded = bus.loaded;
      o_ovf    = bus.ovf;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] pat [8] = '{3'b001, 3'b110, 3'b100, 3'b011,
                          3'b001, 3'b110, 3'b100, 3'b011};

  typedef struct {
    bit s4;
    int ch;
    int addr;
    int data;
    int oob;
  } rvec_t;

  rvec_t rv [23];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Start beat carries a junk symbol that must not be stored.
  task automatic load(input int ch, input int n, input int off, input bit rdchk);
    wr_start = 1'b1;
    wr_ch    = ch[0];
    wr_valid = 1'b1;
    wr_data  = 3'b111;
    step;
    wr_start = 1'b0;
    check("ready_after_start", int'(o_ready), 1);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = pat[(i + off) % 8];
      wr_last  = (i == n - 1);
      if (rdchk) begin
        rd_en   = 1'b1;
        rd_ch   = 1'b0;
        rd_addr = 8'(i % 8);
      end
      step;
      if (rdchk) begin
        check("conc_rd_data",  int'(o_data),  int'(pat[i % 8]));
        check("conc_rd_oob",   int'(o_oob),   0);
        check("conc_rd_valid", int'(o_valid), 1);
      end
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    rd_en    = 1'b0;
    check("ready_after_last", int'(o_ready), 0);
  endtask

  task automatic run_reads(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sel4    = rv[i].s4;
      rd_en   = 1'b1;
      rd_ch   = rv[i].ch[0];
      rd_addr = 8'(rv[i].addr);
      step;
      check($sformatf("rd%0d_valid", i), int'(o_valid), 1);
      check($sformatf("rd%0d_data", i),  int'(o_data),  rv[i].data);
      check($sformatf("rd%0d_oob", i),   int'(o_oob),   rv[i].oob);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rv[i] = '{0, 0, i, int'(pat[i]), 0};
    rv[8]  = '{0, 1, 7,   0, 1};
    rv[9]  = '{0, 1, 127, 0, 1};
    rv[10] = '{0, 1, 6,   3, 0};
    rv[11] = '{0, 0, 8,   0, 1};
    rv[12] = '{0, 1, 0,   6, 0};
    rv[13] = '{1, 0, 0,   1, 0};
    rv[14] = '{1, 0, 1,   6, 0};
    rv[15] = '{1, 0, 2,   4, 0};
    rv[16] = '{1, 0, 3,   3, 0};
    rv[17] = '{1, 0, 4,   0, 1};
    rv[18] = '{1, 0, 2,   1, 0};
    rv[19] = '{1, 0, 3,   0, 1};
    rv[20] = '{1, 0, 0,   4, 0};
    rv[21] = '{0, 0, 0,   4, 0};
    rv[22] = '{0, 0, 1,   3, 0};

    sel4 = 1'b0; wr_start = 1'b0; wr_ch = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    wr_data = '0; rd_en = 1'b0; rd_ch = 1'b0; rd_addr = '0;
    rst = 1'b0;
    step;
    step;
    check("rst_ready",  int'(o_ready),  0);
    check("rst_valid",  int'(o_valid),  0);
    check("rst_oob",    int'(o_oob),    0);
    check("rst_data",   int'(o_data),   0);
    check("rst_len0",   int'(o_len0),   0);
    check("rst_len1",   int'(o_len1),   0);
    check("rst_loaded", int'(o_loaded), 0);
    check("rst_ovf",    int'(o_ovf),    0);
    rst = 1'b1;
    step;

    load(0, 8, 0, 1'b0);
    check("ch0_len",    int'(o_len0),   8);
    check("ch0_loaded", int'(o_loaded), 1);
    check("ch0_ovf",    int'(o_ovf),    0);

    load(1, 7, 1, 1'b1);
    check("ch1_len",    int'(o_len1),   7);
    check("ch1_len0",   int'(o_len0),   8);
    check("ch1_loaded", int'(o_loaded), 3);

    run_reads(0, 12);
    step;
    check("hold_valid", int'(o_valid), 0);
    check("hold_data",  int'(o_data),  6);
    check("hold_oob",   int'(o_oob),   0);

    wr_valid = 1'b1;
    wr_data  = 3'b101;
    step;
    step;
    wr_valid = 1'b0;
    check("idle_wr_ready",  int'(o_ready),  0);
    check("idle_wr_len0",   int'(o_len0),   8);
    check("idle_wr_loaded", int'(o_loaded), 3);

    // wr_start mid-load must not restart or retarget; bare wr_last is inert.
    wr_start = 1'b1; wr_ch = 1'b0;
    step;
    wr_ch = 1'b1; wr_valid = 1'b1; wr_data = pat[2];
    step;
    check("mid_loaded", int'(o_loaded), 2);
    check("mid_len0",   int'(o_len0),   0);
    check("mid_len1",   int'(o_len1),   7);
    wr_start = 1'b0; wr_valid = 1'b0; wr_last = 1'b1;
    rd_en = 1'b1; rd_ch = 1'b0; rd_addr = 8'd0;
    step;
    check("mid_rd_oob",  int'(o_oob),    1);
    check("mid_ready",   int'(o_ready),  1);
    check("mid_loaded2", int'(o_loaded), 2);
    rd_en = 1'b0;
    wr_valid = 1'b1; wr_data = pat[3]; wr_last = 1'b1;
    step;
    wr_valid = 1'b0; wr_last = 1'b0;
    check("mid_end_len0",   int'(o_len0),   2);
    check("mid_end_len1",   int'(o_len1),   7);
    check("mid_end_loaded", int'(o_loaded), 3);
    check("mid_end_ready",  int'(o_ready),  0);
    run_reads(21, 22);

    sel4 = 1'b1;
    load(0, 6, 0, 1'b0);
    check("d4_len",    int'(o_len0),   4);
    check("d4_ovf",    int'(o_ovf),    1);
    check("d4_loaded", int'(o_loaded), 1);
    run_reads(13, 17);
    load(0, 3, 2, 1'b0);
    check("d4_re_len",    int'(o_len0),   3);
    check("d4_re_ovf",    int'(o_ovf),    0);
    check("d4_re_loaded", int'(o_loaded), 1);
    run_reads(18, 20);

    sel4 = 1'b0;
    wr_start = 1'b1; wr_ch = 1'b0;
    step;
    wr_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = pat[i];
      if (i == 2) begin
        rd_en = 1'b1; rd_ch = 1'b1; rd_addr = 8'd0;
      end
      step;
    end
    check("pre_rst_data", int'(o_data), 6);
    rd_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_ready",  int'(o_ready),  0);
    check("arst_valid",  int'(o_valid),  0);
    check("arst_data",   int'(o_data),   0);
    check("arst_len0",   int'(o_len0),   0);
    check("arst_len1",   int'(o_len1),   0);
    check("arst_loaded", int'(o_loaded), 0);
    wr_valid = 1'b0;
    step;
    step;
    rst = 1'b1;
    step;
    wr_valid = 1'b1; wr_data = 3'b001; wr_last = 1'b1;
    step;
    step;
    wr_valid = 1'b0; wr_last = 1'b0;
    check("post_rst_ready",  int'(o_ready),  0);
    check("post_rst_len0",   int'(o_len0),   0);
    check("post_rst_loaded", int'(o_loaded), 0);
    rd_en = 1'b1; rd_ch = 1'b0; rd_addr = 8'd0;
    step;
    rd_en = 1'b0;
    check("post_rst_oob",  int'(o_oob),  1);
    check("post_rst_data", int'(o_data), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
